// File: rtl/rotary_pkg.sv
// Shared constants for the rotary encoder / LED level chain.
package rotary_pkg;

    localparam int CLK_HZ = 40_000_000;

    // WS2812B latch gap plus margin, in microseconds
    localparam int HOLDOFF_US = 60;
    localparam int HOLDOFF_CYCLES_DEF = (CLK_HZ / 1_000_000) * HOLDOFF_US;

    // LED strip length, shared with the decoder and the WS2812B driver
    localparam int LED_COUNT = 12;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_OFFER   = 2'd1,
        ST_HOLDOFF = 2'd2
    } tracker_state_t;

endpackage

// File: rtl/rotary_level_tracker_level_step.sv
// Next-level computation for one rotation step: saturate or wrap at the ends.
module level_step #(
    parameter int LEVEL_MAX = 12,
    parameter int LEVEL_W   = 4,
    parameter int WRAP      = 0
) (
    input  logic [LEVEL_W-1:0] level,
    input  logic               up,
    input  logic               dn,
    output logic [LEVEL_W-1:0] level_next,
    output logic               changed
);

    localparam logic [LEVEL_W-1:0] MAX_L = LEVEL_W'(LEVEL_MAX);

    // Bound check happens before the +1/-1 so unused codes are never produced
    always_comb begin
        level_next = level;
        if (up && !dn) begin
            if (level >= MAX_L) begin
                level_next = (WRAP != 0) ? '0 : MAX_L;
            end else begin
                level_next = level + 1'b1;
            end
        end else if (dn && !up) begin
            if (level == '0) begin
                level_next = (WRAP != 0) ? MAX_L : '0;
            end else begin
                level_next = level - 1'b1;
            end
        end
    end

    assign changed = (level_next != level);

endmodule

// File: rtl/rotary_level_tracker.sv
// Bounded LED level tracker with coalesced frame offers and post-frame holdoff.
//
// state   | meaning
// IDLE    | no offer outstanding; offers a snapshot as soon as dirty is set
// OFFER   | frame_valid high, frame_level frozen until frame_ready
// HOLDOFF | counting down the latch gap after an accepted frame
module rotary_level_tracker
    import rotary_pkg::*;
#(
    parameter int LEVEL_MAX      = LED_COUNT,
    parameter int LEVEL_W        = 4,
    parameter int WRAP           = 0,
    parameter int RESET_LEVEL    = 0,
    parameter int HOLDOFF_CYCLES = HOLDOFF_CYCLES_DEF
) (
    input  logic               clk,
    input  logic               res_n,
    input  logic               rotation_up,
    input  logic               rotation_dn,
    output logic [LEVEL_W-1:0] level,
    output logic               frame_valid,
    input  logic               frame_ready,
    output logic [LEVEL_W-1:0] frame_level,
    output logic               busy
);

    localparam int CNT_W = (HOLDOFF_CYCLES > 1) ? $clog2(HOLDOFF_CYCLES) : 1;
    localparam logic [CNT_W-1:0]   CNT_LOAD  = CNT_W'(HOLDOFF_CYCLES - 1);
    localparam logic [LEVEL_W-1:0] LEVEL_RST = LEVEL_W'(RESET_LEVEL);

    tracker_state_t     state;
    logic [CNT_W-1:0]   cnt;
    logic               dirty;
    logic [LEVEL_W-1:0] level_next;
    logic               changed;

    level_step #(
        .LEVEL_MAX (LEVEL_MAX),
        .LEVEL_W   (LEVEL_W),
        .WRAP      (WRAP)
    ) u_step (
        .level      (level),
        .up         (rotation_up),
        .dn         (rotation_dn),
        .level_next (level_next),
        .changed    (changed)
    );

    // Level tracking plus offer/holdoff sequencing; dirty starts set so the
    // first frame after reset goes out without any rotation
    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            level       <= LEVEL_RST;
            frame_level <= LEVEL_RST;
            frame_valid <= 1'b0;
            busy        <= 1'b0;
            dirty       <= 1'b1;
            cnt         <= '0;
            state       <= ST_IDLE;
        end else begin
            level <= level_next;
            if (changed) begin
                dirty <= 1'b1;
            end
            case (state)
                ST_IDLE: begin
                    if (dirty) begin
                        frame_level <= level;
                        frame_valid <= 1'b1;
                        busy        <= 1'b1;
                        dirty       <= changed;
                        state       <= ST_OFFER;
                    end
                end
                ST_OFFER: begin
                    if (frame_ready) begin
                        frame_valid <= 1'b0;
                        cnt         <= CNT_LOAD;
                        state       <= ST_HOLDOFF;
                    end
                end
                ST_HOLDOFF: begin
                    if (cnt == '0) begin
                        busy  <= 1'b0;
                        state <= ST_IDLE;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: begin
                    frame_valid <= 1'b0;
                    busy        <= 1'b0;
                    state       <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/rotary_level_tracker.md
Name: rotary_level_tracker

Overview:
- Sits directly downstream of the rotary decoder. Consumes its one-cycle rotation_up / rotation_dn pulses.
- Maintains a bounded LED level (number of lit LEDs, 0..LEVEL_MAX).
- Offers level snapshots to the WS2812B frame driver over a valid/ready handshake.
- Coalesces rotations that arrive while a frame is pending or during a post-frame holdoff, so the driver never sees a backlog.

Parameters:
- LEVEL_MAX, 12, highest level (LED count); minimum 1.
- LEVEL_W, 4, width of level buses; must satisfy 2**LEVEL_W > LEVEL_MAX.
- WRAP, 0, 0 = saturate at the ends; 1 = wrap LEVEL_MAX<->0.
- RESET_LEVEL, 0, level after reset; must be <= LEVEL_MAX.
- HOLDOFF_CYCLES, 2400, idle cycles after each accepted frame (60 us at 40 MHz, covers the WS2812B latch gap); minimum 1.

Ports:
- clk  in  1  40 MHz system clock
- res_n  in  1  reset; one clock; reset is asynchronous and active-low
- rotation_up  in  1  one-cycle pulse from decoder, increment
- rotation_dn  in  1  one-cycle pulse from decoder, decrement
- level  out  LEVEL_W  live registered level
- frame_valid  out  1  snapshot offered to frame driver
- frame_ready  in  1  frame driver accepts snapshot
- frame_level  out  LEVEL_W  snapshot; stable while frame_valid=1
- busy  out  1  high in OFFER or HOLDOFF

Behaviour:
- Reset (async assert, sync deassert handled by top-level synchroniser):
  - level=RESET_LEVEL, frame_level=RESET_LEVEL, frame_valid=0, busy=0.
  - State IDLE, holdoff counter 0, dirty=1. The first frame after reset is therefore pushed automatically.
- Level update (every cycle, independent of FSM state):
  - up&!dn: level+1. At LEVEL_MAX, hold (WRAP=0) or go to 0 (WRAP=1).
  - dn&!up: level-1. At 0, hold (WRAP=0) or go to LEVEL_MAX (WRAP=1).
  - up&dn or neither: no change.
  - dirty is set only when level actually changes. A saturated no-op does not set it.
- FSM states: IDLE, OFFER, HOLDOFF.
  - IDLE: if dirty, then frame_level<=level, frame_valid<=1, go to OFFER. dirty is cleared unless a level change occurs in the same cycle; a change in that cycle keeps dirty=1.
  - OFFER: frame_valid=1. frame_level is held, even if level keeps changing.
    - On frame_valid&frame_ready: frame_valid<=0, counter<=HOLDOFF_CYCLES-1, go to HOLDOFF.
    - frame_valid never drops without ready.
  - HOLDOFF: counter decrements each cycle. At 0, go to IDLE. Changes during HOLDOFF only set dirty.
- Latency: a pulse sampled at edge N updates level at edge N. From IDLE with dirty=0, frame_valid rises at edge N+1, carrying the new level.
- Coalescing: any number of changes during OFFER/HOLDOFF produce exactly one further frame, carrying the level current at the IDLE exit.
- Reset mid-OFFER: frame_valid drops immediately (async). The driver must tolerate an abandoned offer.
- frame_ready while not valid: ignored.
- Width: all arithmetic in LEVEL_W bits. Compare against LEVEL_MAX before incrementing; no overflow into unused codes.

Decomposition:
- Shared package rotary_pkg:
  - FSM state localparams (IDLE/OFFER/HOLDOFF, 2 bits).
  - CLK_HZ=40_000_000.
  - Default HOLDOFF_CYCLES derived from CLK_HZ.
  - Default LED count, shared with the decoder and WS2812B driver.
- One sub-module, level_step: combinational next-level/changed computation with LEVEL_MAX/WRAP parameters. This isolates the saturate/wrap rules for unit checks.
- FSM and holdoff counter stay in the top module.

Test Plan:
- Reset release, frame_ready=1, defaults: frame_valid high one cycle after reset with frame_level=0; busy for 2400 cycles; then idle with frame_valid=0.
- 3 up pulses spaced 10 cycles apart after holdoff, ready held low: one frame offered with frame_level=1. level reaches 3 while frame_level stays 1. Raise ready: after 2400 holdoff cycles, exactly one frame with frame_level=3.
- WRAP=0, level=12, 2 up pulses: level stays 12, dirty not set, no frame. From level 0, 1 dn pulse: no frame.
- WRAP=1, LEVEL_MAX=12: up at 12 gives level 0 and a frame with 0. dn at 0 gives level 12 and a frame with 12.
- up and dn asserted in the same cycle at level 5: level stays 5, no frame.
- Reset asserted in OFFER with level=7: frame_valid=0 and level=0 within the same cycle (async). After release, the automatic frame has frame_level=0.
